// File: rtl/sdram_rd_ctrl_if.sv
// sdram_rd_ctrl_if: request, SDRAM command/data and completion signals of the read controller.
interface sdram_rd_ctrl_if #(
    parameter int ROW_W  = 12,
    parameter int COL_W  = 8,
    parameter int BANK_W = 2,
    parameter int DQ_W   = 16
);
    logic                            rd_en;
    logic [BANK_W+ROW_W+COL_W-1:0]   rd_start_addr;
    logic [7:0]                      rd_burst_num;
    logic                            aref_req;
    logic [4:0]                      rd_cmd;
    logic [BANK_W-1:0]               rd_ba;
    logic [ROW_W-1:0]                rd_addr;
    logic [DQ_W-1:0]                 sdram_dq;
    logic [DQ_W-1:0]                 rd_data;
    logic                            rd_data_vld;
    logic                            rd_ack;
    logic                            rd_done;
    logic                            rd_busy;

    modport master (
        input  rd_en, rd_start_addr, rd_burst_num, aref_req, sdram_dq,
        output rd_cmd, rd_ba, rd_addr, rd_data, rd_data_vld, rd_ack, rd_done, rd_busy
    );
    modport slave (
        output rd_en, rd_start_addr, rd_burst_num, aref_req, sdram_dq,
        input  rd_cmd, rd_ba, rd_addr, rd_data, rd_data_vld, rd_ack, rd_done, rd_busy
    );
endinterface

// File: rtl/sdram_rd_ctrl.sv
// sdram_rd_ctrl: SDRAM burst read sequencer with row crossing, refresh yield and CAS-aligned capture.
module sdram_rd_ctrl #(
    parameter int ROW_W     = 12,
    parameter int COL_W     = 8,
    parameter int BANK_W    = 2,
    parameter int BURST_LEN = 4,
    parameter int CAS_LAT   = 2,
    parameter int T_RCD     = 2,
    parameter int T_RP      = 2,
    parameter int DQ_W      = 16
) (
    input logic             S_CLK,
    input logic             RST_N,
    sdram_rd_ctrl_if.master bus
);
    typedef enum logic [2:0] {IDLE, ACT, RCD, RD, PREC, RP, DRAIN} state_t;

    localparam int AW = BANK_W + ROW_W + COL_W;
    localparam int BW = BURST_LEN > 1 ? $clog2(BURST_LEN) : 1;
    localparam int PW = CAS_LAT + BURST_LEN;
    localparam logic [4:0] C_NOP  = 5'b10111;
    localparam logic [4:0] C_ACT  = 5'b10011;
    localparam logic [4:0] C_READ = 5'b10101;
    localparam logic [4:0] C_PREC = 5'b10010;
    localparam logic [ROW_W-1:0] A10       = ROW_W'(1024);
    localparam logic [AW-1:0]    BL_STEP   = AW'(BURST_LEN);
    localparam logic [AW-1:0]    LOW_MASK  = AW'(BURST_LEN - 1);
    localparam logic [BW-1:0]    BEAT_LAST = BW'(BURST_LEN - 1);
    localparam logic [7:0]       RCD_LD    = 8'(T_RCD > 1 ? T_RCD - 2 : 0);
    localparam logic [7:0]       RP_LD     = 8'(T_RP > 1 ? T_RP - 2 : 0);
    // a READ in the current cycle lands its beats CAS_LAT..CAS_LAT+BURST_LEN-1 cycles later
    localparam logic [PW-1:0]    RD_MASK   = PW'(((1 << BURST_LEN) - 1) << CAS_LAT);

    state_t            state_q, state_d, after_rp;
    logic [AW-1:0]     addr_q, addr_d, addr_nx;
    logic [7:0]        cnt_q, cnt_d, cnt_nx;
    logic [BW-1:0]     beat_q, beat_d;
    logic [7:0]        tmr_q, tmr_d;
    logic              cross_q, cross_d;
    logic [PW-1:0]     pipe_q, pipe_d;
    logic [4:0]        cmd_q, cmd_d;
    logic [BANK_W-1:0] ba_q, ba_d;
    logic [ROW_W-1:0]  a_q, a_d;
    logic [DQ_W-1:0]   data_q, data_d;
    logic              vld_q, vld_d, ack_q, ack_d, done_q, done_d, busy_q, busy_d;
    logic              wrap, rd_issue;

    always_ff @(posedge S_CLK) begin
        if (!RST_N) begin
            state_q <= IDLE;
            addr_q  <= '0;
            cnt_q   <= '0;
            beat_q  <= '0;
            tmr_q   <= '0;
            cross_q <= 1'b0;
            pipe_q  <= '0;
            cmd_q   <= C_NOP;
            ba_q    <= '0;
            a_q     <= A10;
            data_q  <= '0;
            vld_q   <= 1'b0;
            ack_q   <= 1'b0;
            done_q  <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            cnt_q   <= cnt_d;
            beat_q  <= beat_d;
            tmr_q   <= tmr_d;
            cross_q <= cross_d;
            pipe_q  <= pipe_d;
            cmd_q   <= cmd_d;
            ba_q    <= ba_d;
            a_q     <= a_d;
            data_q  <= data_d;
            vld_q   <= vld_d;
            ack_q   <= ack_d;
            done_q  <= done_d;
            busy_q  <= busy_d;
        end
    end

    always_comb begin
        addr_nx  = addr_q + BL_STEP;
        cnt_nx   = cnt_q - 8'd1;
        wrap     = addr_nx[COL_W-1:0] == '0;
        after_rp = (cross_q && cnt_q != '0 && !bus.aref_req) ? ACT : DRAIN;
        state_d  = state_q;
        addr_d   = addr_q;
        cnt_d    = cnt_q;
        beat_d   = beat_q;
        tmr_d    = tmr_q;
        cross_d  = cross_q;
        ack_d    = 1'b0;
        done_d   = 1'b0;
        case (state_q)
            IDLE: begin
                if (bus.rd_en && cnt_q == '0 && bus.rd_burst_num == '0) begin
                    ack_d  = 1'b1;
                    done_d = 1'b1;
                end else if (bus.rd_en) begin
                    state_d = ACT;
                    addr_d  = cnt_q == '0 ? bus.rd_start_addr & ~LOW_MASK : addr_q;
                    cnt_d   = cnt_q == '0 ? bus.rd_burst_num : cnt_q;
                end
            end
            ACT: begin
                state_d = T_RCD > 1 ? RCD : RD;
                tmr_d   = RCD_LD;
                beat_d  = '0;
            end
            RCD: begin
                tmr_d   = tmr_q - 8'd1;
                beat_d  = '0;
                state_d = tmr_q == '0 ? RD : RCD;
            end
            RD: begin
                beat_d = beat_q + BW'(1);
                if (beat_q == BEAT_LAST) begin
                    addr_d  = addr_nx;
                    cnt_d   = cnt_nx;
                    beat_d  = '0;
                    cross_d = cnt_nx != '0 && !bus.aref_req && wrap;
                    state_d = (cnt_nx == '0 || bus.aref_req || wrap) ? PREC : RD;
                end
            end
            PREC: begin
                tmr_d   = RP_LD;
                state_d = T_RP > 1 ? RP : after_rp;
            end
            RP: begin
                tmr_d   = tmr_q - 8'd1;
                state_d = tmr_q == '0 ? after_rp : RP;
            end
            DRAIN: begin
                if (pipe_q == '0) begin
                    state_d = IDLE;
                    ack_d   = 1'b1;
                    done_d  = cnt_q == '0;
                end
            end
            default: state_d = IDLE;
        endcase
        // outputs are registered, so they follow the state being entered
        rd_issue = state_d == RD && beat_d == '0;
        cmd_d    = state_d == ACT ? C_ACT : state_d == PREC ? C_PREC : rd_issue ? C_READ : C_NOP;
        ba_d     = (state_d == ACT || rd_issue) ? addr_d[AW-1 -: BANK_W] : '0;
        a_d      = state_d == ACT ? addr_d[COL_W +: ROW_W] : rd_issue ? ROW_W'(addr_d[COL_W-1:0]) : A10;
        pipe_d   = (pipe_q >> 1) | (rd_issue ? RD_MASK : '0);
        data_d   = pipe_q[0] ? bus.sdram_dq : data_q;
        vld_d    = pipe_q[0];
        busy_d   = state_d != IDLE;
    end

    assign bus.rd_cmd      = cmd_q;
    assign bus.rd_ba       = ba_q;
    assign bus.rd_addr     = a_q;
    assign bus.rd_data     = data_q;
    assign bus.rd_data_vld = vld_q;
    assign bus.rd_ack      = ack_q;
    assign bus.rd_done     = done_q;
    assign bus.rd_busy     = busy_q;
endmodule

// File: tb/tb_sdram_rd_ctrl.sv
// tb_sdram_rd_ctrl: directed checks of command sequencing, capture timing, yield and reset.
module tb_sdram_rd_ctrl;
    localparam logic [4:0] E_ACT  = 5'b10011;
    localparam logic [4:0] E_READ = 5'b10101;
    localparam logic [4:0] E_PREC = 5'b10010;
    localparam logic [4:0] E_NOP  = 5'b10111;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int cyc = 0;
    int base = 0;
    int total = 0;
    int bad = 0;
    logic [31:0] cmd_log[$], ack_log[$], exp_c[$], exp_a[$];
    int beat_log[$], exp_b[$];

    sdram_rd_ctrl_if b1 ();
    sdram_rd_ctrl_if b2 ();

    sdram_rd_ctrl dut1 (.S_CLK(clk), .RST_N(rst_n), .bus(b1));
    sdram_rd_ctrl #(.BURST_LEN(8), .CAS_LAT(3), .T_RCD(3)) dut2 (.S_CLK(clk), .RST_N(rst_n), .bus(b2));

    always #5 clk = ~clk;

    function automatic logic [15:0] f(int c);
        return 16'hD000 ^ 16'(c);
    endfunction

    assign b1.sdram_dq = f(cyc);
    assign b2.sdram_dq = f(cyc);

    function automatic logic [31:0] pk(int dc, logic [4:0] c, logic [1:0] ba, logic [11:0] a);
        return {5'd0, 8'(dc), c, ba, a};
    endfunction

    task automatic chk(string tag, logic [31:0] got, logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic rec(logic [4:0] c, logic [1:0] ba, logic [11:0] a, logic v, logic [15:0] d, logic ack, logic dn);
        int dc = cyc - base;
        if (c != E_NOP) cmd_log.push_back(pk(dc, c, ba, a));
        if (v) begin
            beat_log.push_back(dc);
            chk($sformatf("beat data @%0d", dc), 32'(d), 32'(f(cyc)));
        end
        if (ack) ack_log.push_back({dc[30:0], dn});
    endtask

    always @(negedge clk) begin
        rec(b1.rd_cmd, b1.rd_ba, b1.rd_addr, b1.rd_data_vld, b1.rd_data, b1.rd_ack, b1.rd_done);
        rec(b2.rd_cmd, b2.rd_ba, b2.rd_addr, b2.rd_data_vld, b2.rd_data, b2.rd_ack, b2.rd_done);
        cyc++;
    end

    task automatic clear_logs();
        cmd_log.delete();
        beat_log.delete();
        ack_log.delete();
        exp_c.delete();
        exp_b.delete();
        exp_a.delete();
    endtask

    task automatic req(int d, logic [21:0] ad, logic [7:0] n);
        @(negedge clk);
        #1;
        clear_logs();
        base = cyc;
        if (d == 1) begin
            b1.rd_en = 1'b1;
            b1.rd_start_addr = ad;
            b1.rd_burst_num = n;
        end else begin
            b2.rd_en = 1'b1;
            b2.rd_start_addr = ad;
            b2.rd_burst_num = n;
        end
        @(negedge clk);
        #1;
        b1.rd_en = 1'b0;
        b2.rd_en = 1'b0;
    endtask

    task automatic run(string tag, int lim);
        int i = 0;
        while (ack_log.size() == 0 && i < lim) begin
            @(negedge clk);
            #1;
            i++;
        end
        chk({tag, " ack seen"}, 32'(ack_log.size() != 0), 32'd1);
        repeat (3) begin
            @(negedge clk);
            #1;
        end
    endtask

    task automatic add_beats(int s, int n);
        for (int i = 0; i < n; i++) exp_b.push_back(s + i);
    endtask

    task automatic check_logs(string tag);
        chk({tag, " ncmd"}, 32'(cmd_log.size()), 32'(exp_c.size()));
        for (int i = 0; i < exp_c.size() && i < cmd_log.size(); i++)
            chk($sformatf("%s cmd%0d", tag, i), cmd_log[i], exp_c[i]);
        chk({tag, " nbeat"}, 32'(beat_log.size()), 32'(exp_b.size()));
        for (int i = 0; i < exp_b.size() && i < beat_log.size(); i++)
            chk($sformatf("%s beat%0d", tag, i), 32'(beat_log[i]), 32'(exp_b[i]));
        chk({tag, " nack"}, 32'(ack_log.size()), 32'(exp_a.size()));
        for (int i = 0; i < exp_a.size() && i < ack_log.size(); i++)
            chk($sformatf("%s ack%0d", tag, i), ack_log[i], exp_a[i]);
    endtask

    initial begin
        b1.rd_en = 1'b0; b1.rd_start_addr = '0; b1.rd_burst_num = '0; b1.aref_req = 1'b0;
        b2.rd_en = 1'b0; b2.rd_start_addr = '0; b2.rd_burst_num = '0; b2.aref_req = 1'b0;
        repeat (3) @(negedge clk);
        #1;
        chk("rst cmd", 32'(b1.rd_cmd), 32'(E_NOP));
        chk("rst ba", 32'(b1.rd_ba), 32'd0);
        chk("rst addr", 32'(b1.rd_addr), 32'h400);
        chk("rst data", 32'(b1.rd_data), 32'd0);
        chk("rst vld", 32'(b1.rd_data_vld), 32'd0);
        chk("rst ack", 32'(b1.rd_ack), 32'd0);
        chk("rst done", 32'(b1.rd_done), 32'd0);
        chk("rst busy", 32'(b1.rd_busy), 32'd0);
        rst_n = 1'b1;

        req(1, {2'd0, 12'd5, 8'h00}, 8'd2);
        run("basic", 60);
        exp_c = {pk(0, E_ACT, 0, 5), pk(2, E_READ, 0, 0), pk(6, E_READ, 0, 4), pk(10, E_PREC, 0, 12'h400)};
        add_beats(5, 8);
        exp_a = {{31'd13, 1'b1}};
        check_logs("basic");

        req(1, {2'd0, 12'd5, 8'hFC}, 8'd2);
        run("cross", 60);
        exp_c = {pk(0, E_ACT, 0, 5), pk(2, E_READ, 0, 12'h0FC), pk(6, E_PREC, 0, 12'h400),
                 pk(8, E_ACT, 0, 6), pk(10, E_READ, 0, 0), pk(14, E_PREC, 0, 12'h400)};
        add_beats(5, 4);
        add_beats(13, 4);
        exp_a = {{31'd17, 1'b1}};
        check_logs("cross");

        b1.aref_req = 1'b1;
        req(1, {2'd0, 12'd7, 8'h00}, 8'd4);
        run("yield", 60);
        exp_c = {pk(0, E_ACT, 0, 7), pk(2, E_READ, 0, 0), pk(6, E_PREC, 0, 12'h400)};
        add_beats(5, 4);
        exp_a = {{31'd9, 1'b0}};
        check_logs("yield");
        b1.aref_req = 1'b0;

        req(1, {2'd1, 12'd9, 8'h40}, 8'd9);
        run("resume", 80);
        exp_c = {pk(0, E_ACT, 0, 7), pk(2, E_READ, 0, 4), pk(6, E_READ, 0, 8),
                 pk(10, E_READ, 0, 12'h00C), pk(14, E_PREC, 0, 12'h400)};
        add_beats(5, 12);
        exp_a = {{31'd17, 1'b1}};
        check_logs("resume");

        req(1, {2'd3, 12'd1, 8'h20}, 8'd0);
        run("zero", 10);
        exp_a = {{31'd0, 1'b1}};
        check_logs("zero");
        chk("zero busy", 32'(b1.rd_busy), 32'd0);

        req(1, {2'd0, 12'd3, 8'h10}, 8'd3);
        for (int i = 0; i < 40 && cmd_log.size() < 3; i++) begin
            @(negedge clk);
            #1;
        end
        chk("mid reached 2nd read", 32'(cmd_log.size()), 32'd3);
        rst_n = 1'b0;
        @(negedge clk);
        #1;
        chk("mid rst cmd", 32'(b1.rd_cmd), 32'(E_NOP));
        chk("mid rst vld", 32'(b1.rd_data_vld), 32'd0);
        chk("mid rst data", 32'(b1.rd_data), 32'd0);
        chk("mid rst busy", 32'(b1.rd_busy), 32'd0);
        chk("mid rst ack", 32'(b1.rd_ack), 32'd0);
        rst_n = 1'b1;
        clear_logs();
        repeat (5) begin
            @(negedge clk);
            #1;
        end
        check_logs("post rst quiet");

        req(1, {2'd2, 12'h020, 8'h08}, 8'd1);
        run("after rst", 40);
        exp_c = {pk(0, E_ACT, 2, 12'h020), pk(2, E_READ, 2, 8), pk(6, E_PREC, 0, 12'h400)};
        add_beats(5, 4);
        exp_a = {{31'd9, 1'b1}};
        check_logs("after rst");

        req(2, {2'd0, 12'd1, 8'h00}, 8'd1);
        run("cl3", 60);
        exp_c = {pk(0, E_ACT, 0, 1), pk(3, E_READ, 0, 0), pk(11, E_PREC, 0, 12'h400)};
        add_beats(7, 8);
        exp_a = {{31'd15, 1'b1}};
        check_logs("cl3");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/sdram_rd_ctrl.md
SDRAM_RD_CTRL -- requirements
Module: sdram_rd_ctrl

Interface
REQ-001 SHALL have parameter ROW_W, default 12, row address width.
REQ-002 SHALL have parameter COL_W, default 8, column address width.
REQ-003 SHALL have parameter BANK_W, default 2, bank address width.
REQ-004 SHALL have parameter BURST_LEN, default 4, SDRAM burst length; legal values 1/2/4/8.
REQ-005 SHALL have parameter CAS_LAT, default 2, CAS latency; legal values 2/3.
REQ-006 SHALL have parameter T_RCD, default 2, ACT-to-READ cycles; minimum 1.
REQ-007 SHALL have parameter T_RP, default 2, PRECHARGE-to-next-command cycles; minimum 1.
REQ-008 SHALL have parameter DQ_W, default 16, data width.
REQ-009 SHALL have port S_CLK, input, 1 bit, single clock; one clock, all logic on rising edge.
REQ-010 SHALL have port RST_N, input, 1 bit, reset, synchronous, active-low.
REQ-011 SHALL have port rd_en, input, 1 bit, arbiter grant; sampled only in IDLE.
REQ-012 SHALL have port rd_start_addr, input, BANK_W+ROW_W+COL_W bits, start address {bank,row,col}.
REQ-013 SHALL have port rd_burst_num, input, 8 bits, number of bursts to read.
REQ-014 SHALL have port aref_req, input, 1 bit, refresh request from refresh block.
REQ-015 SHALL have port rd_cmd, output, 5 bits, {CKE,CS_N,RAS_N,CAS_N,WE_N}; NOP=10111, ACT=10011, READ=10101, PREC=10010.
REQ-016 SHALL have port rd_ba, output, BANK_W bits, bank address.
REQ-017 SHALL have port rd_addr, output, ROW_W bits, SDRAM address bus.
REQ-018 SHALL have port sdram_dq, input, DQ_W bits, SDRAM read data.
REQ-019 SHALL have port rd_data, output, DQ_W bits, registered captured data.
REQ-020 SHALL have port rd_data_vld, output, 1 bit, qualifies rd_data.
REQ-021 SHALL have port rd_ack, output, 1 bit, one-cycle pulse when the bus is released.
REQ-022 SHALL have port rd_done, output, 1 bit, pulses with rd_ack when all requested bursts are complete.
REQ-023 SHALL have port rd_busy, output, 1 bit, high in every state except IDLE.

Function
REQ-024 SHALL implement states IDLE, ACT, RCD, RD, PREC, RP, DRAIN; every output registered.
REQ-025 IDLE SHALL drive NOP, rd_addr with bit 10 = 1 and all other bits 0, and rd_ba = 0.
REQ-026 rd_en in IDLE with pending count 0 and rd_burst_num 0 SHALL produce rd_ack and rd_done one cycle later, with no ACT issued.
REQ-027 rd_en in IDLE with no pending transfer SHALL latch rd_start_addr, force column bits [log2(BURST_LEN)-1:0] to 0, latch the count, and enter ACT.
REQ-028 rd_en in IDLE with pending count > 0 SHALL resume from the saved pointer and ignore rd_start_addr and rd_burst_num.
REQ-029 ACT SHALL last 1 cycle (cmd ACT, rd_ba = bank, rd_addr = row), followed by T_RCD-1 cycles of NOP in RCD; if T_RCD = 1, ACT goes directly to RD.
REQ-030 RD SHALL issue READ (rd_addr = column, bit 10 = 0) on the first cycle of each burst, then NOP for BURST_LEN-1 cycles.
REQ-031 Successive bursts in the same row SHALL be gapless: the next READ follows the last NOP of the previous burst with no bubble.
REQ-032 After each burst the column SHALL advance by BURST_LEN and the count SHALL decrement.
REQ-033 Column wrap to 0 SHALL carry into row; row wrap SHALL carry into bank; full-address wrap goes to 0.
REQ-034 At the end of each burst, priority SHALL be: count = 0 -> PREC; aref_req = 1 -> PREC (yield); column wrapped -> PREC and then re-enter ACT; otherwise next READ.
REQ-035 PREC SHALL drive cmd PREC with rd_addr bit 10 = 1 for 1 cycle, followed by T_RP-1 NOP cycles in RP.
REQ-036 After RP, a row crossing with count > 0 and aref_req = 0 SHALL go to ACT; otherwise the block SHALL go to DRAIN.
REQ-037 If aref_req is asserted during RP on a row crossing, the block SHALL yield.
REQ-038 Capture SHALL be via a shift pipe: each READ schedules BURST_LEN beats starting CAS_LAT cycles after the READ cycle; rd_data and rd_data_vld are registered from sdram_dq one cycle later.
REQ-039 DRAIN SHALL wait until the capture pipe is empty, then pulse rd_ack, pulse rd_done if count = 0, and return to IDLE in the same cycle.
REQ-040 On a yield, the block SHALL save the remaining count and next address, and rd_done SHALL stay 0.
REQ-041 aref_req SHALL be ignored outside end-of-burst and RP decision points.

Reset
REQ-042 When RST_N = 0 at an edge, the block SHALL go to IDLE and clear the pending count, address, and capture pipe.
REQ-043 Under reset, outputs SHALL be: rd_cmd = NOP, rd_ba = 0, rd_addr = 0x400, rd_data = 0, rd_data_vld = 0, rd_ack = 0, rd_done = 0, rd_busy = 0.
REQ-044 Reset asserted mid-burst SHALL produce NOP on the next edge, with no PREC issued and no rd_ack.

Verification
REQ-045 Defaults, rd_en with addr {0,5,0x00} and count 2 -> ACT row 5; READs col 0x00 and 0x04 with 4 cycles between; 8 vld beats beginning 3 cycles after the first READ; PREC; then rd_ack and rd_done.
REQ-046 Start col 0xFC, count 2 -> READ 0xFC, PREC, ACT row 6, READ 0x00; 8 beats; single rd_done.
REQ-047 aref_req high at the end of burst 1 of 4 -> PREC, rd_ack with rd_done = 0; a new rd_en (different addr) -> resumes at col 0x04, 3 bursts, then rd_done.
REQ-048 rd_en with count 0 -> rd_ack and rd_done after 1 cycle; rd_cmd stays NOP.
REQ-049 Reset pulsed during the 2nd burst -> next cycle NOP and vld = 0; subsequent rd_en uses the new rd_start_addr.
REQ-050 CAS_LAT=3, BURST_LEN=8, T_RCD=3 -> 2 NOPs between ACT and READ; first vld beat 4 cycles after READ.
